mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/lib_rr_arb2.sv | 32 +++
 rtl/mem_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/data memory arbiter
package mem_arb_pkg;

    // Arbiter phase: waiting for a request, or holding the single outstanding slot
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_PEND = 2'd1,
        D_PEND = 2'd2
    } state_t;

    // Requester identity; doubles as the bit index into the grant vector
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_t;

endpackage

// File: rtl/lib_rr_arb2.sv
// rtl/lib_rr_arb2.sv - two-way round-robin grant with last-winner memory
module lib_rr_arb2 #(
    parameter logic LAST_RST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    // Index of the requester that won the most recent accepted grant
    logic last_grant;

    // A lone requester wins outright; on a tie the one not served last wins
    always_comb begin
        gnt = req;
        if (req[0] && req[1]) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner only when the grant is actually consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= LAST_RST;
        end else if (upd && (gnt != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fetch/data arbiter onto one memory port, one transaction in flight
import mem_arb_pkg::*;

module mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_req_vld,
    output logic            i_req_rdy,
    input  logic [AW-1:0]   i_req_addr,
    output logic            i_rsp_vld,
    input  logic            i_rsp_rdy,
    output logic [DW-1:0]   i_rsp_data,

    input  logic            d_req_vld,
    output logic            d_req_rdy,
    input  logic [AW-1:0]   d_req_addr,
    input  logic            d_req_we,
    input  logic [DW-1:0]   d_req_wdata,
    input  logic [DW/8-1:0] d_req_wstrb,
    output logic            d_rsp_vld,
    input  logic            d_rsp_rdy,
    output logic [DW-1:0]   d_rsp_data,

    output logic            m_req_vld,
    input  logic            m_req_rdy,
    output logic [AW-1:0]   m_req_addr,
    output logic            m_req_we,
    output logic [DW-1:0]   m_req_wdata,
    output logic [DW/8-1:0] m_req_wstrb,
    input  logic            m_rsp_vld,
    output logic            m_rsp_rdy,
    input  logic [DW-1:0]   m_rsp_data
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] gnt;
    logic       m_req_hs;

    // Fetch wins the first tie after reset, so last winner starts as data
    lib_rr_arb2 #(
        .LAST_RST (1'b1)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({d_req_vld, i_req_vld}),
        .upd   (m_req_hs),
        .gnt   (gnt)
    );

    // Read data is pure routing; the valids decide who actually sees it
    assign i_rsp_data = m_rsp_data;
    assign d_rsp_data = m_rsp_data;

    // Phase register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request mux, handshake routing and next phase
    always_comb begin
        state_nxt   = state;
        m_req_hs    = 1'b0;
        m_req_vld   = 1'b0;
        i_req_rdy   = 1'b0;
        d_req_rdy   = 1'b0;
        i_rsp_vld   = 1'b0;
        d_rsp_vld   = 1'b0;
        m_rsp_rdy   = 1'b0;
        m_req_addr  = i_req_addr;
        m_req_we    = 1'b0;
        m_req_wdata = '0;
        m_req_wstrb = '0;

        // A fetch never writes, so only a data grant carries we/wdata/wstrb
        if (gnt[REQ_D]) begin
            m_req_addr  = d_req_addr;
            m_req_we    = d_req_we;
            m_req_wdata = d_req_wdata;
            m_req_wstrb = d_req_wstrb;
        end

        case (state)
            IDLE: begin
                m_req_vld = i_req_vld | d_req_vld;
                i_req_rdy = gnt[REQ_I] & m_req_rdy;
                d_req_rdy = gnt[REQ_D] & m_req_rdy;
                m_req_hs  = m_req_vld & m_req_rdy;
                if (m_req_hs) begin
                    state_nxt = gnt[REQ_D] ? D_PEND : I_PEND;
                end
            end
            I_PEND: begin
                i_rsp_vld = m_rsp_vld;
                m_rsp_rdy = i_rsp_rdy;
                if (m_rsp_vld && i_rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            D_PEND: begin
                d_rsp_vld = m_rsp_vld;
                m_rsp_rdy = d_rsp_rdy;
                if (m_rsp_vld && d_rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
